// File: rtl/disp_colr_out_pkg.sv
// Shared display helpers: conversion mode selection, Bayer 4x4 threshold table and
// threshold scaling for ordered dithering.
package disp_colr_out_pkg;

  typedef enum logic [1:0] {
    ModeWiden,
    ModeTrunc,
    ModeDither
  } conv_mode_e;

  // Bayer 4x4 matrix, entry {y,x} at bits [4*{y,x} +: 4]; row 0 is 0,8,2,10.
  localparam logic [63:0] BayerTbl = {
    4'd5,  4'd13, 4'd7,  4'd15,
    4'd9,  4'd1,  4'd11, 4'd3,
    4'd6,  4'd14, 4'd4,  4'd12,
    4'd10, 4'd2,  4'd8,  4'd0
  };

  function automatic conv_mode_e conv_mode(int unsigned bin, int unsigned bout,
                                           int unsigned dither);
    if (bout >= bin) return ModeWiden;
    else if (dither == 0) return ModeTrunc;
    else return ModeDither;
  endfunction

  function automatic logic [3:0] bayer_thr(logic [1:0] x4, logic [1:0] y4);
    logic [5:0] idx;
    idx = {y4, x4, 2'b00};
    return BayerTbl[idx +: 4];
  endfunction

  // Scale the 4-bit threshold so its range matches the D discarded bits.
  function automatic logic [15:0] thr_scale(logic [3:0] t, int unsigned d);
    if (d <= 4) return 16'(t) >> (4 - d);
    else return 16'(t) << (d - 4);
  endfunction

endpackage

// File: rtl/disp_colr_out_colr_conv.sv
// One colour channel: depth conversion (replicate, truncate or ordered dither) followed by
// the first pipeline register. Colour is blanked to zero when DE is low.
module disp_colr_out_colr_conv
  import disp_colr_out_pkg::*;
#(
  parameter int unsigned BPC_IN  = 5,
  parameter int unsigned BPC_OUT = 8,
  parameter int unsigned DITHER  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_de,
  input  logic [1:0]         i_x4,
  input  logic [1:0]         i_y4,
  input  logic [BPC_IN-1:0]  i_c,
  output logic [BPC_OUT-1:0] o_c
);

  localparam conv_mode_e Mode = conv_mode(BPC_IN, BPC_OUT, DITHER);

  logic [BPC_OUT-1:0] w_conv;
  logic [BPC_OUT-1:0] r_c;

  if (Mode == ModeWiden) begin : g_widen
    logic w_unused;
    assign w_unused = ^{i_x4, i_y4};
    // Repeat the input MSB-first until the output is full.
    for (genvar k = 0; k < BPC_OUT; k++) begin : g_rep
      assign w_conv[BPC_OUT-1-k] = i_c[BPC_IN-1-(k%BPC_IN)];
    end
  end else if (Mode == ModeTrunc) begin : g_trunc
    logic w_unused;
    assign w_unused = ^{i_x4, i_y4};
    assign w_conv   = i_c[BPC_IN-1 -: BPC_OUT];
  end else begin : g_dither
    localparam int unsigned D  = BPC_IN - BPC_OUT;
    localparam int unsigned SW = BPC_IN + 1;
    logic [SW-1:0]     w_sum;
    logic [BPC_IN-1:0] w_sat;
    assign w_sum  = SW'(i_c) + SW'(thr_scale(bayer_thr(i_x4, i_y4), D));
    // Saturate so bright input never wraps to black.
    assign w_sat  = w_sum[SW-1] ? '1 : w_sum[BPC_IN-1:0];
    assign w_conv = w_sat[BPC_IN-1 -: BPC_OUT];
  end

  // First pipeline stage, zeroed outside DE.
  always_ff @(posedge clk) begin
    if (!rst_n) r_c <= '0;
    else        r_c <= i_de ? w_conv : '0;
  end

  assign o_c = r_c;

endmodule

// File: rtl/disp_colr_out.sv
// Display output stage: per-channel colour depth conversion, dither position counters and
// a matched-latency pipeline for sync, DE and colour.
module disp_colr_out
  import disp_colr_out_pkg::*;
#(
  parameter int unsigned BPC_IN   = 5,
  parameter int unsigned BPC_OUT  = 8,
  parameter int unsigned LAT      = 2,
  parameter int unsigned DITHER   = 1,
  parameter int unsigned TEMPORAL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic               in_de,
  input  logic               in_frame,
  input  logic [BPC_IN-1:0]  in_r,
  input  logic [BPC_IN-1:0]  in_g,
  input  logic [BPC_IN-1:0]  in_b,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic [BPC_OUT-1:0] out_r,
  output logic [BPC_OUT-1:0] out_g,
  output logic [BPC_OUT-1:0] out_b
);

  localparam int unsigned PW = 3 * BPC_OUT + 3;

  logic [1:0] r_x, r_y, r_f;
  logic       r_de_prev;
  logic [2:0] r_sync1;
  logic [1:0] w_x4, w_y4;
  logic [BPC_OUT-1:0] w_r1, w_g1, w_b1;
  logic [PW-1:0] w_st1, w_out;

  // Position counters track the pixel currently on the inputs; frame pulse wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_f       <= '0;
      r_de_prev <= 1'b0;
    end else begin
      r_de_prev <= in_de;
      if (in_frame) begin
        r_x <= '0;
        r_y <= '0;
        r_f <= r_f + 2'd1;
      end else if (in_de) begin
        r_x <= r_x + 2'd1;
      end else if (r_de_prev) begin
        r_x <= '0;
        r_y <= r_y + 2'd1;
      end
    end
  end

  assign w_x4 = (TEMPORAL != 0) ? (r_x ^ r_f) : r_x;
  assign w_y4 = (TEMPORAL != 0) ? (r_y ^ {r_f[0], r_f[1]}) : r_y;

  // First stage for sync/DE, aligned with the channel converters' register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_sync1 <= '0;
    else        r_sync1 <= {in_hsync, in_vsync, in_de};
  end

  disp_colr_out_colr_conv #(
    .BPC_IN (BPC_IN),
    .BPC_OUT(BPC_OUT),
    .DITHER (DITHER)
  ) u_conv_r (
    .clk  (clk),
    .rst_n(rst_n),
    .i_de (in_de),
    .i_x4 (w_x4),
    .i_y4 (w_y4),
    .i_c  (in_r),
    .o_c  (w_r1)
  );

  disp_colr_out_colr_conv #(
    .BPC_IN (BPC_IN),
    .BPC_OUT(BPC_OUT),
    .DITHER (DITHER)
  ) u_conv_g (
    .clk  (clk),
    .rst_n(rst_n),
    .i_de (in_de),
    .i_x4 (w_x4),
    .i_y4 (w_y4),
    .i_c  (in_g),
    .o_c  (w_g1)
  );

  disp_colr_out_colr_conv #(
    .BPC_IN (BPC_IN),
    .BPC_OUT(BPC_OUT),
    .DITHER (DITHER)
  ) u_conv_b (
    .clk  (clk),
    .rst_n(rst_n),
    .i_de (in_de),
    .i_x4 (w_x4),
    .i_y4 (w_y4),
    .i_c  (in_b),
    .o_c  (w_b1)
  );

  assign w_st1 = {r_sync1, w_r1, w_g1, w_b1};

  if (LAT > 1) begin : g_dly
    logic [PW-1:0] r_dly [LAT-1];
    // Remaining LAT-1 stages shared by sync, DE and colour.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT - 1; i++) r_dly[i] <= '0;
      end else begin
        r_dly[0] <= w_st1;
        for (int i = 1; i < LAT - 1; i++) r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_out = r_dly[LAT-2];
  end else begin : g_nodly
    assign w_out = w_st1;
  end

  assign {out_hsync, out_vsync, out_de, out_r, out_g, out_b} = w_out;

endmodule

// File: tb/tb_disp_colr_out.sv
// Scoreboard bench for disp_colr_out: five configurations share one stimulus stream;
// expected outputs come from an arithmetic reference model and are checked by a monitor.
module tb_disp_colr_out;

  localparam int NDUT = 5;

  typedef struct {
    int          due;
    logic [38:0] v;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$], q4[$];

  int p_bin [NDUT] = '{5, 8, 8, 8, 12};
  int p_bout[NDUT] = '{8, 5, 6, 6, 2};
  int p_lat [NDUT] = '{2, 3, 2, 1, 4};
  int p_dith[NDUT] = '{1, 0, 1, 1, 1};
  int p_temp[NDUT] = '{1, 1, 1, 0, 1};
  int bayer_tbl[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int mx = 0, my = 0, mf = 0;
  bit mprev = 0;

  logic clk = 1'b0;
  logic rst_n, hsync, vsync, de, frame;
  logic [11:0] r12, g12, b12;

  logic a_hs, a_vs, a_de; logic [7:0]  a_r, a_g, a_b;
  logic b_hs, b_vs, b_de; logic [4:0]  b_r, b_g, b_b;
  logic c_hs, c_vs, c_de; logic [5:0]  c_r, c_g, c_b;
  logic d_hs, d_vs, d_de; logic [5:0]  d_r, d_g, d_b;
  logic e_hs, e_vs, e_de; logic [1:0]  e_r, e_g, e_b;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  disp_colr_out #(.BPC_IN(5), .BPC_OUT(8), .LAT(2), .DITHER(1), .TEMPORAL(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_hsync(hsync), .in_vsync(vsync), .in_de(de),
    .in_frame(frame), .in_r(r12[4:0]), .in_g(g12[4:0]), .in_b(b12[4:0]),
    .out_hsync(a_hs), .out_vsync(a_vs), .out_de(a_de), .out_r(a_r), .out_g(a_g), .out_b(a_b));
  disp_colr_out #(.BPC_IN(8), .BPC_OUT(5), .LAT(3), .DITHER(0), .TEMPORAL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_hsync(hsync), .in_vsync(vsync), .in_de(de),
    .in_frame(frame), .in_r(r12[7:0]), .in_g(g12[7:0]), .in_b(b12[7:0]),
    .out_hsync(b_hs), .out_vsync(b_vs), .out_de(b_de), .out_r(b_r), .out_g(b_g), .out_b(b_b));
  disp_colr_out #(.BPC_IN(8), .BPC_OUT(6), .LAT(2), .DITHER(1), .TEMPORAL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_hsync(hsync), .in_vsync(vsync), .in_de(de),
    .in_frame(frame), .in_r(r12[7:0]), .in_g(g12[7:0]), .in_b(b12[7:0]),
    .out_hsync(c_hs), .out_vsync(c_vs), .out_de(c_de), .out_r(c_r), .out_g(c_g), .out_b(c_b));
  disp_colr_out #(.BPC_IN(8), .BPC_OUT(6), .LAT(1), .DITHER(1), .TEMPORAL(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_hsync(hsync), .in_vsync(vsync), .in_de(de),
    .in_frame(frame), .in_r(r12[7:0]), .in_g(g12[7:0]), .in_b(b12[7:0]),
    .out_hsync(d_hs), .out_vsync(d_vs), .out_de(d_de), .out_r(d_r), .out_g(d_g), .out_b(d_b));
  disp_colr_out #(.BPC_IN(12), .BPC_OUT(2), .LAT(4), .DITHER(1), .TEMPORAL(1)) u_e (
    .clk(clk), .rst_n(rst_n), .in_hsync(hsync), .in_vsync(vsync), .in_de(de),
    .in_frame(frame), .in_r(r12), .in_g(g12), .in_b(b12),
    .out_hsync(e_hs), .out_vsync(e_vs), .out_de(e_de), .out_r(e_r), .out_g(e_g), .out_b(e_b));

  // Reference conversion straight from the arithmetic rules.
  function automatic int ref_conv(int id, int c);
    int bin, bout, d, x4, y4, t, ts, s, res;
    bin  = p_bin[id];
    bout = p_bout[id];
    if (bout >= bin) begin
      res = 0;
      for (int k = 0; k < bout; k++)
        res |= ((c >> (bin - 1 - (k % bin))) & 1) << (bout - 1 - k);
      return res;
    end
    d = bin - bout;
    if (p_dith[id] == 0) return c >> d;
    x4 = mx & 3;
    y4 = my & 3;
    if (p_temp[id] != 0) begin
      x4 = x4 ^ (mf & 3);
      y4 = y4 ^ (((mf & 1) << 1) | ((mf >> 1) & 1));
    end
    t  = bayer_tbl[y4 * 4 + x4];
    ts = (d <= 4) ? (t >> (4 - d)) : (t << (d - 4));
    s  = c + ts;
    if (s > (1 << bin) - 1) s = (1 << bin) - 1;
    return s >> d;
  endfunction

  function automatic logic [11:0] chan(int id, logic [11:0] c, bit d);
    if (!d) return 12'h000;
    return 12'(ref_conv(id, int'(c) & ((1 << p_bin[id]) - 1)));
  endfunction

  task automatic push(int id, exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q3.push_back(e);
      default: q4.push_back(e);
    endcase
  endtask

  // Drop expectations that a reset at the coming edge overrides.
  task automatic trim(int id);
    case (id)
      0: while (q0.size() > 0 && q0[$].due > edge_n) void'(q0.pop_back());
      1: while (q1.size() > 0 && q1[$].due > edge_n) void'(q1.pop_back());
      2: while (q2.size() > 0 && q2[$].due > edge_n) void'(q2.pop_back());
      3: while (q3.size() > 0 && q3[$].due > edge_n) void'(q3.pop_back());
      default: while (q4.size() > 0 && q4[$].due > edge_n) void'(q4.pop_back());
    endcase
  endtask

  task automatic mon(int id, logic [38:0] act);
    exp_t e;
    bit   have;
    have = 0;
    case (id)
      0: if (q0.size() > 0 && q0[0].due == edge_n) begin e = q0.pop_front(); have = 1; end
      1: if (q1.size() > 0 && q1[0].due == edge_n) begin e = q1.pop_front(); have = 1; end
      2: if (q2.size() > 0 && q2[0].due == edge_n) begin e = q2.pop_front(); have = 1; end
      3: if (q3.size() > 0 && q3[0].due == edge_n) begin e = q3.pop_front(); have = 1; end
      default:
        if (q4.size() > 0 && q4[0].due == edge_n) begin e = q4.pop_front(); have = 1; end
    endcase
    if (have) begin
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL dut%0d edge %0d: got {hs,vs,de,r,g,b}=%h, expected %h",
                 id, edge_n, act, e.v);
      end
    end
  endtask

  // Monitor: compare whatever each DUT presents against its due expectation.
  always @(negedge clk) begin
    mon(0, {a_hs, a_vs, a_de, 12'(a_r), 12'(a_g), 12'(a_b)});
    mon(1, {b_hs, b_vs, b_de, 12'(b_r), 12'(b_g), 12'(b_b)});
    mon(2, {c_hs, c_vs, c_de, 12'(c_r), 12'(c_g), 12'(c_b)});
    mon(3, {d_hs, d_vs, d_de, 12'(d_r), 12'(d_g), 12'(d_b)});
    mon(4, {e_hs, e_vs, e_de, 12'(e_r), 12'(e_g), 12'(e_b)});
  end

  task automatic step(bit rn, bit hs, bit vs, bit d, bit frm,
                      logic [11:0] r, logic [11:0] g, logic [11:0] b);
    exp_t e;
    rst_n = rn; hsync = hs; vsync = vs; de = d; frame = frm;
    r12 = r; g12 = g; b12 = b;
    for (int id = 0; id < NDUT; id++) begin
      if (!rn) begin
        trim(id);
        for (int k = 1; k <= p_lat[id]; k++) begin
          e.due = edge_n + k;
          e.v   = '0;
          push(id, e);
        end
      end else begin
        e.due = edge_n + p_lat[id];
        e.v   = {hs, vs, d, chan(id, r, d), chan(id, g, d), chan(id, b, d)};
        push(id, e);
      end
    end
    if (!rn) begin
      mx = 0; my = 0; mf = 0; mprev = 0;
    end else begin
      if (frm) begin
        mx = 0; my = 0; mf = (mf + 1) & 3;
      end else if (d) begin
        mx = (mx + 1) & 3;
      end else if (mprev) begin
        mx = 0; my = (my + 1) & 3;
      end
      mprev = d;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] rnd12();
    return 12'($urandom);
  endfunction

  logic [11:0] dir_vals[8] = '{12'h01F, 12'h010, 12'h000, 12'h0FF,
                               12'h084, 12'h007, 12'h082, 12'hFFF};

  initial begin
    logic [11:0] v;
    rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; de = 1'b0; frame = 1'b0;
    r12 = '0; g12 = '0; b12 = '0;

    repeat (3) step(0, 0, 0, 1, 0, 12'hFFF, 12'hFFF, 12'hFFF);
    repeat (2) step(1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000);

    // Directed widen/truncate values on one active line.
    foreach (dir_vals[i]) step(1, 0, 0, 1, 0, dir_vals[i], rnd12(), rnd12());
    step(1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000);

    // Sync pulse during blanking with non-zero colour.
    step(1, 1, 0, 0, 0, 12'h01F, 12'h01F, 12'h01F);
    repeat (2) step(1, 0, 0, 0, 0, 12'h01F, 12'h01F, 12'h01F);

    // Flat 4x4 blocks over three frames: two mid-grey, one full white.
    for (int fr = 0; fr < 3; fr++) begin
      v = (fr < 2) ? 12'h082 : 12'hFFF;
      step(1, 0, 1, 0, 1, 12'h000, 12'h000, 12'h000);
      for (int yy = 0; yy < 4; yy++) begin
        for (int xx = 0; xx < 4; xx++) step(1, 0, 0, 1, 0, v, v, v);
        step(1, 1, 0, 0, 0, 12'h000, 12'h000, 12'h000);
        step(1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000);
      end
    end

    // Reset in the middle of an active line.
    step(1, 0, 1, 0, 1, 12'h000, 12'h000, 12'h000);
    repeat (5) step(1, 0, 0, 1, 0, 12'h082, 12'h082, 12'h082);
    step(0, 1, 1, 1, 0, 12'h082, 12'h082, 12'h082);
    repeat (6) step(1, 0, 0, 1, 0, 12'h082, 12'h082, 12'h082);
    step(1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000);

    // Randomised lines, gaps, frame pulses and occasional resets.
    for (int ln = 0; ln < 150; ln++) begin
      int len, gap;
      len = $urandom_range(1, 24);
      gap = $urandom_range(1, 4);
      for (int p = 0; p < len; p++)
        step(($urandom_range(0, 299) != 0), 1'($urandom), 1'($urandom), 1, 0,
             rnd12(), rnd12(), rnd12());
      for (int g = 0; g < gap; g++)
        step(1, 1'($urandom), 1'($urandom), 0, ($urandom_range(0, 9) == 0),
             rnd12(), rnd12(), rnd12());
    end

    // Let the pipelines drain, then every expectation must have been consumed.
    repeat (6) @(posedge clk);
    #1;
    for (int id = 0; id < NDUT; id++) begin
      int left;
      case (id)
        0: left = q0.size();
        1: left = q1.size();
        2: left = q2.size();
        3: left = q3.size();
        default: left = q4.size();
      endcase
      vectors++;
      if (left != 0) begin
        miscompares++;
        $display("FAIL dut%0d drain: %0d expectations left, required 0", id, left);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
